clock_divider_bank: RTL and testbench

- Multi-channel, runtime-programmable clock-enable/divided-clock generator.
- Generalises the fixed single-output divider: each channel has its own period, its own high time (duty cycle) and its own enable.
- Each channel also emits a one-cycle tick at the start of every period.
- Sits between the system clock and peripheral/CPU-stage logic; configured through a simple write port.

---
 rtl/clock_divider_bank.sv | 145 ++++++++++++++
 tb/tb_clock_divider_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - multi-channel programmable divided-clock / tick generator (optional CLKDIV_SYNC_EN adds sync_start)
module clock_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic [WIDTH-1:0]    wr_high,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_start,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] cfg_pending
);

    localparam logic [WIDTH-1:0] DIV_INIT  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] HIGH_INIT = WIDTH'(DEFAULT_DIV / 2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // cnt holds the period index k that the next enabled edge will put on the outputs
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] p_act;
        logic [WIDTH-1:0] h_act;
        logic [WIDTH-1:0] p_sh;
        logic [WIDTH-1:0] h_sh;
        // run is clear for the one arming cycle after en rises (or after a stop)
        logic             run;
        logic             clk_r;
        logic             tick_r;
        logic             pend_r;

        logic             wr_hit;
        logic             apply_ok;
        logic [WIDTH-1:0] p_new;
        logic [WIDTH-1:0] h_new;
        logic [WIDTH-1:0] p_eff;
        logic [WIDTH-1:0] h_eff;
        logic             sync_hit;

        // an address beyond the last channel never matches any i, so it is dropped
        assign wr_hit   = wr_en && (wr_chan == CW'(i));
        assign apply_ok = pend_r || wr_hit;
        // a write landing this cycle beats the stored shadow
        assign p_new    = wr_hit ? wr_div  : p_sh;
        assign h_new    = wr_hit ? wr_high : h_sh;
        assign p_eff    = apply_ok ? p_new : p_act;
        assign h_eff    = apply_ok ? h_new : h_act;

`ifdef CLKDIV_SYNC_EN
        assign sync_hit = sync_start;
`else
        assign sync_hit = 1'b0;
`endif

        assign clk_out[i]     = clk_r;
        assign tick[i]        = tick_r;
        assign cfg_pending[i] = pend_r;

        // per-channel counter, shadow/active configuration and registered outputs
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                p_act  <= DIV_INIT;
                h_act  <= HIGH_INIT;
                p_sh   <= DIV_INIT;
                h_sh   <= HIGH_INIT;
                run    <= 1'b0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
                pend_r <= 1'b0;
            end else begin
                if (wr_hit) begin
                    p_sh   <= wr_div;
                    h_sh   <= wr_high;
                    pend_r <= 1'b1;
                end

                if (!en[i] || p_act == '0) begin
                    // stopped: outputs low, and there is no period to protect so apply at once
                    cnt    <= '0;
                    run    <= 1'b0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                    if (apply_ok) begin
                        p_act  <= p_new;
                        h_act  <= h_new;
                        p_sh   <= p_new;
                        h_sh   <= h_new;
                        pend_r <= 1'b0;
                    end
                end else if (sync_hit) begin
                    // phase alignment: jump straight to k=0 using the freshest configuration
                    if (apply_ok) begin
                        p_act  <= p_new;
                        h_act  <= h_new;
                        p_sh   <= p_new;
                        h_sh   <= h_new;
                        pend_r <= 1'b0;
                    end
                    if (p_eff == '0) begin
                        cnt    <= '0;
                        run    <= 1'b0;
                        clk_r  <= 1'b0;
                        tick_r <= 1'b0;
                    end else begin
                        cnt    <= (p_eff == ONE) ? '0 : ONE;
                        run    <= 1'b1;
                        clk_r  <= (h_eff != '0);
                        tick_r <= 1'b1;
                    end
                end else if (!run) begin
                    cnt    <= '0;
                    run    <= 1'b1;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else begin
                    clk_r  <= (cnt < h_act);
                    tick_r <= (cnt == '0);
                    if (cnt >= p_act - ONE) begin
                        // wrap cycle: the next period starts with the shadow values
                        cnt <= '0;
                        if (apply_ok) begin
                            p_act  <= p_new;
                            h_act  <= h_new;
                            p_sh   <= p_new;
                            h_sh   <= h_new;
                            pend_r <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed plus randomized bench for clock_divider_bank against an integer reference model
module tb_clock_divider_bank;

    localparam int CH = 5;
    localparam int W  = 16;
    localparam int DD = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          wr_en;
    logic [CW-1:0] wr_chan;
    logic [W-1:0]  wr_div;
    logic [W-1:0]  wr_high;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] cfg_pending;

    int compared   = 0;
    int mismatched = 0;

    // reference model: per channel period/high, shadow, pending and the k due next (-1 = arming)
    int m_p[CH];
    int m_h[CH];
    int m_sp[CH];
    int m_sh[CH];
    int m_pend[CH];
    int m_k[CH];
    int m_clk[CH];
    int m_tick[CH];

    clock_divider_bank #(
        .CHANNELS(CH),
        .WIDTH(W),
        .DEFAULT_DIV(DD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .wr_en(wr_en),
        .wr_chan(wr_chan),
        .wr_div(wr_div),
        .wr_high(wr_high),
`ifdef CLKDIV_SYNC_EN
        .sync_start(1'b0),
`endif
        .clk_out(clk_out),
        .tick(tick),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit rst, input logic [CH-1:0] e, input bit we,
                              input int ch, input int d, input int h);
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                m_p[i] = DD; m_h[i] = DD / 2; m_sp[i] = DD; m_sh[i] = DD / 2;
                m_pend[i] = 0; m_k[i] = -1; m_clk[i] = 0; m_tick[i] = 0;
            end else begin
                if (we && ch == i) begin
                    m_sp[i] = d; m_sh[i] = h; m_pend[i] = 1;
                end
                if (!e[i] || m_p[i] == 0) begin
                    m_clk[i] = 0; m_tick[i] = 0; m_k[i] = -1;
                    if (m_pend[i] != 0) begin
                        m_p[i] = m_sp[i]; m_h[i] = m_sh[i]; m_pend[i] = 0;
                    end
                end else if (m_k[i] < 0) begin
                    m_clk[i] = 0; m_tick[i] = 0; m_k[i] = 0;
                end else begin
                    m_clk[i]  = (m_k[i] < m_h[i]) ? 1 : 0;
                    m_tick[i] = (m_k[i] == 0) ? 1 : 0;
                    if (m_k[i] == m_p[i] - 1) begin
                        m_k[i] = 0;
                        if (m_pend[i] != 0) begin
                            m_p[i] = m_sp[i]; m_h[i] = m_sh[i]; m_pend[i] = 0;
                        end
                    end else begin
                        m_k[i] = m_k[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [CH-1:0] ec, et, ep;
        for (int i = 0; i < CH; i++) begin
            ec[i] = (m_clk[i] != 0);
            et[i] = (m_tick[i] != 0);
            ep[i] = (m_pend[i] != 0);
        end
        compared++;
        assert (clk_out === ec) else begin
            mismatched++;
            $error("FAIL clk_out observed=%b expected=%b at %0t", clk_out, ec, $time);
        end
        compared++;
        assert (tick === et) else begin
            mismatched++;
            $error("FAIL tick observed=%b expected=%b at %0t", tick, et, $time);
        end
        compared++;
        assert (cfg_pending === ep) else begin
            mismatched++;
            $error("FAIL cfg_pending observed=%b expected=%b at %0t", cfg_pending, ep, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [CH-1:0] e, input bit we,
                        input int ch, input int d, input int h);
        @(negedge clk);
        check_outputs();
        reset   = rst;
        en      = e;
        wr_en   = we;
        wr_chan = CW'(ch);
        wr_div  = W'(d);
        wr_high = W'(h);
        model_step(rst, e, we, ch, d, h);
        @(posedge clk);
    endtask

    task automatic idle(input logic [CH-1:0] e, input int n);
        for (int c = 0; c < n; c++) step(1'b0, e, 1'b0, 0, 0, 0);
    endtask

    initial begin
        logic [CH-1:0] e_r;
        reset = 1'b1; en = '0; wr_en = 1'b0; wr_chan = '0; wr_div = '0; wr_high = '0;
        model_step(1'b1, '0, 1'b0, 0, 0, 0);
        step(1'b1, '0, 1'b0, 0, 0, 0);
        step(1'b1, '0, 1'b0, 0, 0, 0);

        @(negedge clk);
        compared++;
        assert ({clk_out, tick, cfg_pending} === '0) else begin
            mismatched++;
            $error("FAIL reset_state observed=%b expected=0", {clk_out, tick, cfg_pending});
        end

        // ch0 at default divide: 1,1,0,0 with tick at k=0
        idle(5'b00001, 11);
        // reprogram ch0 mid-period to P=5 H=1
        step(1'b0, 5'b00001, 1'b1, 0, 5, 1);
        idle(5'b00001, 14);

        // ch2 stopped by P=0 after its period, then restarted with H>=P
        idle(5'b00101, 6);
        step(1'b0, 5'b00101, 1'b1, 2, 0, 2);
        idle(5'b00101, 8);
        step(1'b0, 5'b00101, 1'b1, 2, 3, 3);
        idle(5'b00101, 10);

        // ch1 P=1 H=0, then an out-of-range channel write
        step(1'b0, 5'b00111, 1'b1, 1, 1, 0);
        idle(5'b00111, 6);
        step(1'b0, 5'b00111, 1'b1, 5, 9, 9);
        idle(5'b00111, 3);
        step(1'b0, 5'b00111, 1'b1, 7, 2, 2);
        idle(5'b00111, 2);

        // pending write then drop en[0] mid-period, then re-raise
        step(1'b0, 5'b00111, 1'b1, 0, 3, 2);
        idle(5'b00110, 3);
        idle(5'b00111, 9);

        // reset mid-period
        step(1'b1, 5'b00111, 1'b0, 0, 0, 0);
        idle(5'b11111, 12);

        // randomized traffic
        e_r = 5'b11111;
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(15) == 0) e_r[i] = ~e_r[i];
            step(($urandom_range(199) == 0), e_r, ($urandom_range(2) == 0),
                 int'($urandom_range(7)), int'($urandom_range(6)), int'($urandom_range(7)));
        end

        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
